// File: rtl/voting_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : voting_pkg
// Brief    : Shared poll-session state encoding and candidate constants.
// Revision : 1.0
// ----------------------------------------------------------------------------
package voting_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CAND_NONE = 0;

endpackage
`default_nettype wire

// File: rtl/vote_counter_sat.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : vote_counter_sat
// Brief    : CNT_W-bit saturating up-counter with sync clear and enable.
// Revision : 1.0
// ----------------------------------------------------------------------------
module vote_counter_sat #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] r_count;

    assign count = r_count;
    assign sat   = &r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && !sat) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/voting_tally_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : voting_tally_n
// Brief    : NUM_CAND-candidate poll with saturating tallies, sequential
//            winner scan with tie detection and registered count read-back.
// Revision : 1.0
// ----------------------------------------------------------------------------
module voting_tally_n
    import voting_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int CAND_W   = $clog2(NUM_CAND + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    open_poll,
    input  logic                    close_poll,
    input  logic                    vote_valid,
    input  logic [CAND_W-1:0]       vote_cand,
    output logic                    vote_ready,
    output logic                    vote_reject,
    input  logic [CAND_W-1:0]       rd_cand,
    output logic [CNT_W-1:0]        rd_count,
    output logic [CNT_W+CAND_W-1:0] total_votes,
    output logic                    busy,
    output logic                    result_valid,
    output logic [CAND_W-1:0]       winner,
    output logic                    tie
);

    localparam int TOT_W = CNT_W + CAND_W;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CAND_W-1:0]     r_idx;
    logic [CAND_W-1:0]     r_winner;
    logic                  r_tie;
    logic [CNT_W-1:0]      r_best_cnt;
    logic                  r_reject;
    logic [CNT_W-1:0]      r_rd;
    logic [TOT_W-1:0]      r_total;

    logic [CNT_W-1:0]      w_tally [1:NUM_CAND];
    logic [NUM_CAND:1]     w_sat;
    logic [NUM_CAND:1]     w_inc;
    logic                  w_clear;
    logic                  w_hs;
    logic                  w_code_ok;
    logic                  w_sel_sat;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_rd_cnt;
    logic [CNT_W-1:0]      w_scan_cnt;

    assign vote_ready   = (r_state == OPEN);
    assign busy         = (r_state == SCAN);
    assign result_valid = (r_state == DONE);
    assign vote_reject  = r_reject;
    assign rd_count     = r_rd;
    assign total_votes  = r_total;
    assign winner       = r_winner;
    assign tie          = r_tie;

    assign w_clear   = open_poll && ((r_state == IDLE) || (r_state == DONE));
    assign w_hs      = vote_valid && vote_ready;
    assign w_code_ok = (vote_cand != CAND_W'(CAND_NONE)) &&
                       (vote_cand <= CAND_W'(NUM_CAND));
    assign w_accept  = w_hs && w_code_ok && !w_sel_sat;

    // Tally lookups for the vote path, the read-back port and the scan.
    always_comb begin
        w_sel_sat  = 1'b0;
        w_rd_cnt   = '0;
        w_scan_cnt = '0;
        for (int i = 1; i <= NUM_CAND; i++) begin
            if (vote_cand == CAND_W'(i)) w_sel_sat  = w_sat[i];
            if (rd_cand   == CAND_W'(i)) w_rd_cnt   = w_tally[i];
            if (r_idx     == CAND_W'(i)) w_scan_cnt = w_tally[i];
        end
    end

    generate
        for (genvar g = 1; g <= NUM_CAND; g++) begin : g_cnt
            assign w_inc[g] = w_accept && (vote_cand == CAND_W'(g));
            vote_counter_sat #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .clr   (w_clear),
                .inc   (w_inc[g]),
                .count (w_tally[g]),
                .sat   (w_sat[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (open_poll)  w_state_nxt = OPEN;
            OPEN:    if (close_poll) w_state_nxt = SCAN;
            SCAN:    if (r_idx == CAND_W'(NUM_CAND)) w_state_nxt = DONE;
            DONE:    if (open_poll)  w_state_nxt = OPEN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_winner   <= '0;
            r_tie      <= 1'b0;
            r_best_cnt <= '0;
            r_reject   <= 1'b0;
            r_rd       <= '0;
            r_total    <= '0;
        end else begin
            r_reject <= w_hs && !w_accept;
            r_rd     <= w_rd_cnt;

            if (w_clear) begin
                r_total <= '0;
            end else if (w_accept) begin
                r_total <= r_total + 1'b1;
            end

            case (r_state)
                OPEN: begin
                    if (close_poll) r_idx <= CAND_W'(1);
                end
                SCAN: begin
                    r_idx <= r_idx + 1'b1;
                    // Strictly-greater replacement keeps the lowest code on ties.
                    if (r_idx == CAND_W'(1)) begin
                        r_winner   <= CAND_W'(1);
                        r_best_cnt <= w_scan_cnt;
                        r_tie      <= 1'b0;
                    end else if (w_scan_cnt > r_best_cnt) begin
                        r_winner   <= r_idx;
                        r_best_cnt <= w_scan_cnt;
                        r_tie      <= 1'b0;
                    end else if (w_scan_cnt == r_best_cnt) begin
                        r_tie      <= 1'b1;
                    end
                end
                DONE: begin
                    if (open_poll) begin
                        r_winner <= '0;
                        r_tie    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_voting_tally_n.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_voting_tally_n
// Brief    : Two builds (CNT_W=8 and CNT_W=2) driven in lockstep against a
//            per-session reference model of the poll rules.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_voting_tally_n;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, open_poll, close_poll, vote_valid;
    logic [2:0] vote_cand, rd_cand;

    logic       ready [2];
    logic       rej   [2];
    logic       bsy   [2];
    logic       rv    [2];
    logic       tie_o [2];
    logic [2:0] win   [2];
    logic [7:0] rdc8;
    logic [1:0] rdc2;
    logic [10:0] tot8;
    logic [4:0]  tot2;

    voting_tally_n #(.NUM_CAND(N), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
        .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_ready(ready[0]),
        .vote_reject(rej[0]), .rd_cand(rd_cand), .rd_count(rdc8),
        .total_votes(tot8), .busy(bsy[0]), .result_valid(rv[0]),
        .winner(win[0]), .tie(tie_o[0])
    );

    voting_tally_n #(.NUM_CAND(N), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .open_poll(open_poll), .close_poll(close_poll),
        .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_ready(ready[1]),
        .vote_reject(rej[1]), .rd_cand(rd_cand), .rd_count(rdc2),
        .total_votes(tot2), .busy(bsy[1]), .result_valid(rv[1]),
        .winner(win[1]), .tie(tie_o[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference: session phase 0 idle, 1 open, 2 scan, 3 done.
    int tal  [2][1:N];
    int tot  [2];
    int mx   [2] = '{255, 3};
    int erej [2];
    int erd  [2];
    int ew   [2];
    int et   [2];
    int phase = 0;
    int left  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tallies();
        for (int m = 0; m < 2; m++) begin
            tot[m] = 0;
            for (int i = 1; i <= N; i++) tal[m][i] = 0;
        end
    endtask

    task automatic pick_winner();
        for (int m = 0; m < 2; m++) begin
            int best, nbest;
            best = -1;
            for (int i = 1; i <= N; i++) if (tal[m][i] > best) best = tal[m][i];
            nbest = 0;
            ew[m] = 0;
            for (int i = N; i >= 1; i--) if (tal[m][i] == best) begin
                ew[m] = i;
                nbest++;
            end
            et[m] = (nbest > 1) ? 1 : 0;
        end
    endtask

    task automatic model_edge(input bit r, op, cl, vv, input int vc, rc);
        for (int m = 0; m < 2; m++) begin
            erd[m]  = (rc >= 1 && rc <= N) ? tal[m][rc] : 0;
            erej[m] = 0;
        end
        if (r) begin
            clear_tallies();
            for (int m = 0; m < 2; m++) begin ew[m] = 0; et[m] = 0; erd[m] = 0; end
            phase = 0;
        end else begin
            case (phase)
                0: if (op) begin clear_tallies(); phase = 1; end
                1: begin
                    if (vv) begin
                        for (int m = 0; m < 2; m++) begin
                            if (vc >= 1 && vc <= N && tal[m][vc] < mx[m]) begin
                                tal[m][vc]++;
                                tot[m]++;
                            end else begin
                                erej[m] = 1;
                            end
                        end
                    end
                    if (cl) begin pick_winner(); phase = 2; left = N; end
                end
                2: begin left--; if (left == 0) phase = 3; end
                default: if (op) begin
                    clear_tallies();
                    for (int m = 0; m < 2; m++) begin ew[m] = 0; et[m] = 0; end
                    phase = 1;
                end
            endcase
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("ready%0d", m), 32'(ready[m]), 32'(phase == 1));
            check($sformatf("busy%0d", m),  32'(bsy[m]),   32'(phase == 2));
            check($sformatf("rvalid%0d", m), 32'(rv[m]),   32'(phase == 3));
            check($sformatf("reject%0d", m), 32'(rej[m]),  32'(erej[m]));
            check($sformatf("total%0d", m), (m == 0) ? 32'(tot8) : 32'(tot2), 32'(tot[m]));
            check($sformatf("rdcount%0d", m), (m == 0) ? 32'(rdc8) : 32'(rdc2), 32'(erd[m]));
            if (phase == 3 || phase <= 1) begin
                check($sformatf("winner%0d", m), 32'(win[m]),   32'(phase == 3 ? ew[m] : 0));
                check($sformatf("tie%0d", m),    32'(tie_o[m]), 32'(phase == 3 ? et[m] : 0));
            end
        end
    endtask

    task automatic cyc(input bit r, op, cl, vv, input int vc, rc);
        logic [31:0] vcv, rcv;
        vcv = vc;
        rcv = rc;
        rst = r; open_poll = op; close_poll = cl; vote_valid = vv;
        vote_cand = vcv[2:0];
        rd_cand   = rcv[2:0];
        @(posedge clk);
        model_edge(r, op, cl, vv, vc, rc);
        #1;
        compare();
    endtask

    task automatic idle(input int n, input int rc);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, rc);
    endtask

    task automatic vote(input int c);
        cyc(0, 0, 0, 1, c, c);
    endtask

    int vlist1 [5] = '{2, 2, 3, 1, 2};
    int vlist2 [4] = '{1, 3, 3, 1};

    initial begin
        rst = 1'b1; open_poll = 1'b0; close_poll = 1'b0; vote_valid = 1'b0;
        vote_cand = '0; rd_cand = '0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 2, 2);

        // Clear majority, then read back candidate 2.
        cyc(0, 1, 0, 0, 0, 0);
        foreach (vlist1[i]) vote(vlist1[i]);
        cyc(0, 0, 1, 0, 0, 2);
        idle(6, 2);

        // Two-way tie, then an empty session.
        cyc(0, 1, 1, 0, 0, 1);
        foreach (vlist2[i]) vote(vlist2[i]);
        cyc(0, 0, 1, 0, 0, 3);
        idle(5, 1);
        cyc(0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        idle(5, 1);

        // Bad codes, then votes offered outside OPEN.
        cyc(0, 1, 0, 0, 0, 0);
        vote(0);
        vote(5);
        vote(7);
        cyc(0, 0, 1, 0, 0, 5);
        idle(5, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 2, 2);
        cyc(0, 0, 0, 1, 3, 3);

        // Saturation in the narrow build.
        cyc(0, 1, 0, 0, 0, 4);
        for (int i = 0; i < 5; i++) vote(4);
        cyc(0, 0, 1, 0, 0, 4);
        idle(5, 4);

        // Vote coinciding with close, then open+close together in OPEN.
        cyc(0, 1, 0, 0, 0, 3);
        cyc(0, 0, 1, 1, 3, 3);
        idle(5, 3);
        cyc(0, 1, 0, 0, 0, 3);
        vote(1);
        cyc(0, 1, 1, 0, 0, 1);
        idle(2, 1);
        cyc(1, 0, 0, 0, 0, 1);
        idle(2, 1);
        cyc(0, 1, 0, 0, 0, 2);
        vote(2);
        cyc(0, 0, 1, 0, 0, 2);
        idle(5, 2);
        cyc(0, 1, 0, 0, 0, 2);
        idle(1, 2);

        // Randomised sessions.
        for (int s = 0; s < 40; s++) begin
            int nv;
            if ($urandom_range(0, 7) == 0) cyc(1, 0, 0, 0, 0, $urandom_range(0, 6));
            cyc(0, 1, 0, 0, 0, $urandom_range(0, 6));
            nv = $urandom_range(0, 14);
            for (int i = 0; i < nv; i++)
                cyc(0, $urandom_range(0, 5) == 0, 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 6), $urandom_range(0, 6));
            cyc(0, $urandom_range(0, 1), 1, $urandom_range(0, 1),
                $urandom_range(0, 6), $urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0) begin
                idle($urandom_range(0, 3), $urandom_range(0, 6));
                cyc(1, 0, 0, 0, 0, $urandom_range(0, 6));
            end
            for (int i = 0; i < N + 2; i++)
                cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 6), $urandom_range(0, 6));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
